// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, derived totals and sync-window bounds.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END = DEF_V_SYNC_START + DEF_V_SYNC;
  function automatic logic in_window(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/vga_counter.sv
// vga_counter: 0..MAX-1 wrapping counter with increment enable and wrap strobe.
module vga_counter #(
  parameter int MAX = 800
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        inc,
  output logic [10:0] count,
  output logic        wrap
);
  assign wrap = inc && count == 11'(MAX - 1);
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) count <= '0;
    else if (inc) count <= wrap ? '0 : count + 11'd1;
endmodule

// File: rtl/vga_core.sv
// vga_core: VGA raster timing generator; define VGA_CORE_REG_OUT_EN for registered,
// one-cycle-delayed outputs (all five stay aligned).
import vga_timing_pkg::*;
module vga_core #(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        pixel_clock,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [10:0] x,
  output logic [10:0] y
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] HSS = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSS = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSE = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [10:0] hc, vc;
  logic h_wrap, frame_end_unused;
  logic hs_d, vs_d, bl_d;
  vga_counter #(.MAX(H_TOTAL)) u_h (
    .pixel_clock(pixel_clock), .reset(reset), .inc(1'b1), .count(hc), .wrap(h_wrap)
  );
  vga_counter #(.MAX(V_TOTAL)) u_v (
    .pixel_clock(pixel_clock), .reset(reset), .inc(h_wrap), .count(vc), .wrap(frame_end_unused)
  );
  assign hs_d = in_window(hc, HSS, HSE) ? HSYNC_POL : ~HSYNC_POL;
  assign vs_d = in_window(vc, VSS, VSE) ? VSYNC_POL : ~VSYNC_POL;
  assign bl_d = hc >= HA || vc >= VA;
`ifdef VGA_CORE_REG_OUT_EN
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      x     <= '0;
      y     <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      blank <= 1'b0;
    end else begin
      x     <= hc;
      y     <= vc;
      hsync <= hs_d;
      vsync <= vs_d;
      blank <= bl_d;
    end
`else
  assign x = hc;
  assign y = vc;
  assign hsync = hs_d;
  assign vsync = vs_d;
  assign blank = bl_d;
`endif
endmodule

// File: tb/tb_vga_core.sv
// tb_vga_core: directed checks of vga_core at default timing and a tiny active-high-sync mode.
module tb_vga_core;
`ifdef VGA_CORE_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  logic pixel_clock = 1'b0;
  logic reset, reset_s;
  logic hsync, vsync, blank, hsync_s, vsync_s, blank_s;
  logic [10:0] x, y, x_s, y_s;
  int vectors = 0, miscompares = 0;
  always #5 pixel_clock = ~pixel_clock;
  vga_core dut (
    .pixel_clock(pixel_clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .blank(blank), .x(x), .y(y)
  );
  vga_core #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .pixel_clock(pixel_clock), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
    .blank(blank_s), .x(x_s), .y(y_s)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_pos(input string tag, input int p, input int ha, input int hf, input int hs,
                           input int hb, input int va, input int vf, input int vs, input int vb,
                           input logic hp, input logic vp, input logic [10:0] gx, input logic [10:0] gy,
                           input logic ghs, input logic gvs, input logic gbl);
    int ht, vt, ex, ey;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ex = p % ht;
    ey = (p / ht) % vt;
    check({tag, " x"}, gx, ex);
    check({tag, " y"}, gy, ey);
    check({tag, " hsync"}, ghs, (ex >= ha + hf && ex < ha + hf + hs) ? hp : !hp);
    check({tag, " vsync"}, gvs, (ey >= va + vf && ey < va + vf + vs) ? vp : !vp);
    check({tag, " blank"}, gbl, ex >= ha || ey >= va);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " big x"}, x, 0);
    check({tag, " big y"}, y, 0);
    check({tag, " big hsync"}, hsync, 1);
    check({tag, " big vsync"}, vsync, 1);
    check({tag, " big blank"}, blank, 0);
    check({tag, " small x"}, x_s, 0);
    check({tag, " small y"}, y_s, 0);
    check({tag, " small hsync"}, hsync_s, 0);
    check({tag, " small vsync"}, vsync_s, 0);
    check({tag, " small blank"}, blank_s, 0);
  endtask
  initial begin
    int hs_low, first_low, vs_hi, p;
    reset = 1'b1;
    reset_s = 1'b1;
    repeat (3) @(negedge pixel_clock);
    check_reset_vals("reset");
    reset = 1'b0;
    reset_s = 1'b0;
    hs_low = 0;
    first_low = -1;
    vs_hi = 0;
    for (int n = 1; n <= 1900 + LAT; n++) begin
      @(negedge pixel_clock);
      p = n - LAT;
      check_pos("big", p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, x, y, hsync, vsync, blank);
      if (n <= 330) check_pos("small", p, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1, 1'b1, x_s, y_s, hsync_s, vsync_s, blank_s);
      if (p < 800 && !hsync) begin
        hs_low++;
        if (first_low < 0) first_low = int'(x);
      end
      if (p < 160 && vsync_s) vs_hi++;
    end
    check("hsync low count", hs_low, 96);
    check("hsync first low x", first_low, 656);
    check("small vsync high count", vs_hi, 32);
    #2;
    reset = 1'b1;
    reset_s = 1'b1;
    #1;
    check_reset_vals("async reset");
    @(negedge pixel_clock);
    check_reset_vals("held reset");
    reset = 1'b0;
    reset_s = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge pixel_clock);
      p = n - LAT;
      check_pos("big post", p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, x, y, hsync, vsync, blank);
      check_pos("small post", p, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1, 1'b1, x_s, y_s, hsync_s, vsync_s, blank_s);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
